// File: rtl/ysyx_22041211_mem_stage.sv
// ---------------------------------------------------------------------------
// ysyx_22041211_mem_stage
//
// Memory-access stage between execute and write-back. It takes one execute
// result at a time. Loads and stores become a single request on a valid/ready
// data-memory port, followed by a wait for the response. All other results
// pass straight through to write-back.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   in_*                execute-side handshake and operands
//   mem_req_*           data-memory request (word address, lane data, strobes)
//   mem_rsp_*           data-memory response (read word or write acknowledge)
//   out_valid_o/ready_i write-back handshake
//   wd_o/wreg_o/wdata_o write-back enable, register index and value
//   misalign_o          only when YSYX_22041211_MISALIGN_CHECK_EN is defined
//
// Configuration
//   YSYX_22041211_MISALIGN_CHECK_EN: trap misaligned LH/LHU/SH/LW/SW accesses
//   in DONE with misalign_o = 1, without issuing a memory request. When the
//   macro is undefined, misaligned accesses are issued and the lane shifts
//   drop whatever falls off the top.
// ---------------------------------------------------------------------------
module ysyx_22041211_mem_stage #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic                mem_wen_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [1:0]          store_type_i,
  input  logic [2:0]          load_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [DATA_LEN-1:0] mem_req_addr_o,
  output logic                mem_req_wen_o,
  output logic [DATA_LEN-1:0] mem_req_wdata_o,
  output logic [3:0]          mem_req_wstrb_o,
  input  logic                mem_rsp_valid_i,
  input  logic [DATA_LEN-1:0] mem_rsp_rdata_i,
  output logic                mem_rsp_ready_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o
`ifdef YSYX_22041211_MISALIGN_CHECK_EN
  ,
  output logic                misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LW  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  state_e              state_q;
  logic [1:0]          off_q;
  logic [2:0]          ld_type_q;
  logic [DATA_LEN-1:0] addr_q;
  logic                wen_q;
  logic [DATA_LEN-1:0] req_wdata_q;
  logic [3:0]          wstrb_q;
  logic                wd_q;
  logic [4:0]          wreg_q;
  logic [DATA_LEN-1:0] wdata_q;

  // ---- accept-side decode ------------------------------------------------
  logic [1:0]          off_d;
  logic                is_load_d;
  logic                go_mem_d;
  logic [3:0]          strb_base_d;
  logic [3:0]          st_wstrb_d;
  logic [DATA_LEN-1:0] st_wdata_d;

  assign off_d     = alu_result_i[1:0];
  // Encodings 110/111 fall outside 1..5 and behave as "no load".
  assign is_load_d = (load_type_i != 3'b000) && (load_type_i <= LD_LHU);
  assign go_mem_d  = mem_wen_i | is_load_d;

  // Shifting into a fixed-width result drops lanes past byte 3 on purpose.
  assign st_wdata_d = mem_wdata_i << {off_d, 3'b000};

  // NOTE: every variable written in always_comb gets a default first, so a
  // missed case arm cannot infer a latch.
  always_comb begin
    strb_base_d = 4'b0000;
    case (store_type_i)
      2'b01:   strb_base_d = 4'b0001;
      2'b10:   strb_base_d = 4'b0011;
      2'b11:   strb_base_d = 4'b1111;
      default: strb_base_d = 4'b0000;
    endcase
    st_wstrb_d = mem_wen_i ? (strb_base_d << off_d) : 4'b0000;
  end

`ifdef YSYX_22041211_MISALIGN_CHECK_EN
  logic misalign_d;
  logic misalign_q;

  // A store takes priority, so only its size decides alignment when both are set.
  always_comb begin
    misalign_d = 1'b0;
    if (mem_wen_i) begin
      case (store_type_i)
        2'b10:   misalign_d = off_d[0];
        2'b11:   misalign_d = (off_d != 2'b00);
        default: misalign_d = 1'b0;
      endcase
    end else if (is_load_d) begin
      case (load_type_i)
        LD_LH, LD_LHU: misalign_d = off_d[0];
        LD_LW:         misalign_d = (off_d != 2'b00);
        default:       misalign_d = 1'b0;
      endcase
    end
  end

  assign misalign_o = misalign_q;
`endif

  // ---- response-side formatting -------------------------------------------
  logic [DATA_LEN-1:0] ld_sh_d;
  logic [DATA_LEN-1:0] ld_data_d;

  assign ld_sh_d = mem_rsp_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ld_data_d = ld_sh_d;
    case (ld_type_q)
      LD_LB:   ld_data_d = {{24{ld_sh_d[7]}}, ld_sh_d[7:0]};
      LD_LBU:  ld_data_d = {24'h0, ld_sh_d[7:0]};
      LD_LH:   ld_data_d = {{16{ld_sh_d[15]}}, ld_sh_d[15:0]};
      LD_LHU:  ld_data_d = {16'h0, ld_sh_d[15:0]};
      default: ld_data_d = ld_sh_d;
    endcase
  end

  // ---- FSM and transaction registers --------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well because they drive
      // ports directly and those ports must read zero out of reset.
      state_q     <= IDLE;
      off_q       <= 2'b00;
      ld_type_q   <= 3'b000;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      req_wdata_q <= '0;
      wstrb_q     <= 4'b0000;
      wd_q        <= 1'b0;
      wreg_q      <= 5'd0;
      wdata_q     <= '0;
`ifdef YSYX_22041211_MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            off_q       <= off_d;
            ld_type_q   <= load_type_i;
            addr_q      <= {alu_result_i[DATA_LEN-1:2], 2'b00};
            wen_q       <= mem_wen_i;
            req_wdata_q <= st_wdata_d;
            wstrb_q     <= st_wstrb_d;
            wd_q        <= wd_i;
            wreg_q      <= wreg_i;
`ifdef YSYX_22041211_MISALIGN_CHECK_EN
            if (misalign_d) begin
              wd_q       <= 1'b0;
              wdata_q    <= '0;
              misalign_q <= 1'b1;
              state_q    <= DONE;
            end else
`endif
            if (go_mem_d) begin
              state_q <= REQ;
            end else begin
              wdata_q <= alu_result_i;
              state_q <= DONE;
            end
          end
        end
        REQ: begin
          if (mem_req_ready_i) state_q <= RESP;
        end
        RESP: begin
          if (mem_rsp_valid_i) begin
            wdata_q <= wen_q ? '0 : ld_data_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
`ifdef YSYX_22041211_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign in_ready_o      = (state_q == IDLE);
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_rsp_ready_o = (state_q == RESP);
  assign out_valid_o     = (state_q == DONE);

  assign mem_req_addr_o  = addr_q;
  assign mem_req_wen_o   = wen_q;
  assign mem_req_wdata_o = req_wdata_q;
  assign mem_req_wstrb_o = wstrb_q;
  assign wd_o            = wd_q;
  assign wreg_o          = wreg_q;
  assign wdata_o         = wdata_q;

endmodule
